// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - host-side handshake bundle of the UART receiver
// master is the receiver side, slave is the host logic consuming bytes.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 rdy_clr;
  logic [DATA_BITS-1:0] data_out;
  logic                 rdy;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;
  logic                 Rx_busy;

  modport master (
    input  rdy_clr,
    output data_out, rdy, frame_err, overrun, parity_err, Rx_busy
  );

  modport slave (
    output rdy_clr,
    input  data_out, rdy, frame_err, overrun, parity_err, Rx_busy
  );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receive FSM with ready/clear handshake
// Define UART_RX_PARITY_EN to receive start + data + even parity + stop frames.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk_50m,
  input  logic             clr,
  input  logic             clken,
  input  logic             Rx,
  uart_receiver_if.master  host
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic                 rx_meta_q, rx_s_q;
  logic [2:0]           state_q, state_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 good, bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    good    = 1'b0;
    bad     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    if (clken) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d = START;
            scnt_d  = '0;
          end
        end
        START: begin
          if (scnt_q == S_MID) begin
            scnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        DATA: begin
          if (scnt_q == S_END) begin
            scnt_d          = '0;
            shift_d[bcnt_q] = rx_s_q;
            bcnt_d          = bcnt_q + 1'b1;
            if (bcnt_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (scnt_q == S_END) begin
            scnt_d    = '0;
            par_bad_d = (^shift_q) ^ rx_s_q;
            state_d   = STOP;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          // Leave on the mid-bit sample so a back-to-back start edge is not missed.
          if (scnt_q == S_END) begin
            scnt_d  = '0;
            state_d = IDLE;
            good    = rx_s_q;
            bad     = ~rx_s_q;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A completing good byte takes priority over a same-cycle acknowledge.
  always_comb begin
    data_d      = good ? shift_q : data_q;
    rdy_d       = good | (rdy_q & ~host.rdy_clr);
    overrun_d   = ~host.rdy_clr & (overrun_q | (good & rdy_q));
    frame_err_d = bad | (frame_err_q & ~host.rdy_clr);
`ifdef UART_RX_PARITY_EN
    parity_err_d = (good & par_bad_q) | (parity_err_q & ~host.rdy_clr);
`endif
  end

  always_ff @(posedge clk_50m) begin
    if (clr) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      scnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= Rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign host.data_out  = data_q;
  assign host.rdy       = rdy_q;
  assign host.frame_err = frame_err_q;
  assign host.overrun   = overrun_q;
  assign host.Rx_busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign host.parity_err = parity_err_q;
`else
  assign host.parity_err = 1'b0;
`endif
endmodule
